exp2_stream: RTL

EXP2_STREAM -- requirements
Module: exp2_stream

---
 rtl/exp2_pkg.sv | 21 ++
 rtl/exp2_mant.sv | 38 +++
 rtl/exp2_stream.sv | 130 +++++++++++++
 3 files changed

// File: rtl/exp2_pkg.sv
// exp2_pkg: shared constants and types for the exp2_stream pipeline.
//   CORR_NUM / CORR_SHIFT : quadratic-correction coefficient 11/32 used by exp2_mant
//                           when EXP2_STREAM_CORR_EN is defined.
//   MAX_W                 : field width of stage registers. Instances must satisfy
//                           FIX_POINT_WIDTH <= MAX_W.
//   stage_t               : one pipeline stage register (valid, u, v or m, ovf, udf).
package exp2_pkg;

    localparam int unsigned CORR_NUM   = 11;
    localparam int unsigned CORR_SHIFT = 5;
    localparam int unsigned MAX_W      = 32;

    typedef struct packed {
        logic                    valid;
        logic signed [MAX_W-1:0] u;    // integer part, sign-extended
        logic        [MAX_W-1:0] vm;   // fraction v (S1) or mantissa m (S2), zero-extended
        logic                    ovf;
        logic                    udf;
    } stage_t;

endpackage

// File: rtl/exp2_mant.sv
// exp2_mant: combinational mantissa m ~ 2^v for fraction v in [0,1), Q1.Bf result.
//   v_i : Bf-bit unsigned fraction
//   m_o : Bf+1-bit mantissa, 2^Bf represents 1.0
// Macro EXP2_STREAM_CORR_EN: when defined, subtracts the quadratic correction
// (v*(1-v)*11/32) from the linear estimate 1+v; otherwise m = 1+v and no multiplier exists.
module exp2_mant
    import exp2_pkg::*;
#(
    parameter int unsigned Bf = 8
) (
    input  logic [Bf-1:0] v_i,
    output logic [Bf:0]   m_o
);

`ifdef EXP2_STREAM_CORR_EN
    // Wide enough for v * (2^Bf - v) * 11 without wrapping.
    localparam int unsigned PW = 2 * Bf + 6;

    logic [PW-1:0] prod;
    logic [PW-1:0] corr;
    logic [PW-1:0] sum;

    always_comb begin
        prod = PW'(v_i) * ((PW'(1) << Bf) - PW'(v_i)) * PW'(CORR_NUM);
        corr = prod >> (Bf + CORR_SHIFT);
        sum  = (PW'(1) << Bf) + PW'(v_i) - corr;
        m_o  = sum[Bf:0];
    end

    logic unused_sum;
    assign unused_sum = ^sum[PW-1:Bf+1];
`else
    always_comb begin
        m_o = {1'b1, v_i};
    end
`endif

endmodule

// File: rtl/exp2_stream.sv
// exp2_stream: streaming fixed-point 2^x, three-stage pipeline with valid/ready.
//   clk, rst (sync, active-high)
//   in_valid/in_ready/in    : signed Q(W-Bf).Bf exponent x
//   out_valid/out_ready/out : unsigned Q(W-Bf).Bf result
//   out_u                   : floor(x)
//   out_ovf / out_udf       : result saturated to all ones / flushed to zero
// S1 splits x into u and v, S2 forms the mantissa (exp2_mant), S3 shifts and saturates.
// The whole pipeline advances together whenever the output register is free or drained.
// Macro EXP2_STREAM_CORR_EN selects the corrected mantissa inside exp2_mant.
module exp2_stream
    import exp2_pkg::*;
#(
    parameter int unsigned FIX_POINT_WIDTH = 16,
    parameter int unsigned Bf              = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FIX_POINT_WIDTH-1:0]   in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FIX_POINT_WIDTH-1:0]   out,
    output logic [FIX_POINT_WIDTH-Bf-1:0] out_u,
    output logic                         out_ovf,
    output logic                         out_udf
);

    localparam int unsigned UW  = FIX_POINT_WIDTH - Bf;
    // Holds m << u for every non-saturating u without wrapping.
    localparam int unsigned SHW = FIX_POINT_WIDTH + Bf + 1;

    stage_t s1_q, s1_d, s2_q, s2_d;

    logic                       out_valid_q, out_valid_d;
    logic [FIX_POINT_WIDTH-1:0] out_q, out_d;
    logic [UW-1:0]              out_u_q, out_u_d;
    logic                       ovf_q, ovf_d;
    logic                       udf_q, udf_d;

    logic                    adv;
    logic [Bf:0]             m;
    logic signed [MAX_W-1:0] s1_u, s1_neg, s2_u;
    logic [MAX_W-1:0]        shamt;
    logic [SHW-1:0]          shl, shr;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    exp2_mant #(
        .Bf (Bf)
    ) u_mant (
        .v_i (s1_q.vm[Bf-1:0]),
        .m_o (m)
    );

    // S1: decode
    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.u     = MAX_W'($signed(in[FIX_POINT_WIDTH-1:Bf]));
        s1_d.vm    = MAX_W'(in[Bf-1:0]);
    end

    // S2: mantissa and saturation decision, taken on u alone
    always_comb begin
        s1_u       = s1_q.u;
        s1_neg     = -s1_u;
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.u     = s1_q.u;
        s2_d.vm    = MAX_W'(m);
        s2_d.ovf   = s1_u >= $signed(MAX_W'(UW));
        s2_d.udf   = s1_u[MAX_W-1] && (s1_neg >= $signed(MAX_W'(Bf + 1)));
    end

    // S3: shift and saturate
    always_comb begin
        s2_u        = s2_q.u;
        shamt       = s2_u[MAX_W-1] ? $unsigned(-s2_u) : $unsigned(s2_u);
        shl         = SHW'(s2_q.vm[Bf:0]) << shamt;
        shr         = SHW'(s2_q.vm[Bf:0]) >> shamt;
        out_valid_d = s2_q.valid;
        out_u_d     = s2_q.u[UW-1:0];
        ovf_d       = s2_q.ovf;
        udf_d       = s2_q.udf;
        if (s2_q.ovf) begin
            out_d = '1;
        end else if (s2_q.udf) begin
            out_d = '0;
        end else if (s2_u[MAX_W-1]) begin
            out_d = shr[FIX_POINT_WIDTH-1:0];
        end else begin
            out_d = shl[FIX_POINT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_u_q     <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else if (adv) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_u_q     <= out_u_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_u     = out_u_q;
    assign out_ovf   = ovf_q;
    assign out_udf   = udf_q;

    // Bits that are structurally zero or never needed for a non-saturated result.
    logic unused_bits;
    assign unused_bits = ^{s1_q.vm[MAX_W-1:Bf], s1_q.ovf, s1_q.udf,
                           s2_q.vm[MAX_W-1:Bf+1], shl[SHW-1:FIX_POINT_WIDTH],
                           shr[SHW-1:FIX_POINT_WIDTH]};

endmodule
